// File: rtl/adc_multich_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_multich_sampler_if
// Description : Bundle of control, Avalon-ST command/response and sample-output
//               signals between the scan sequencer and its environment.
//               master : sequencer side (drives command, samples and flags)
//               slave  : environment side (ADC core + controller)
//   enable, ch_mask, err_clear          : run control
//   cmd_valid/channel/sop/eop, cmd_ready: Avalon-ST command port
//   rsp_valid/channel/data              : ADC core response
//   out_valid/channel/data, scan_done   : averaged sample stream
//   overrun_err, timeout_err, mismatch_err : sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_multich_sampler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12
);
  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              err_clear;
  logic              cmd_valid;
  logic [4:0]        cmd_channel;
  logic              cmd_sop;
  logic              cmd_eop;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [4:0]        rsp_channel;
  logic [DATA_W-1:0] rsp_data;
  logic              out_valid;
  logic [2:0]        out_channel;
  logic [DATA_W-1:0] out_data;
  logic              scan_done;
  logic              overrun_err;
  logic              timeout_err;
  logic              mismatch_err;

  modport master (
    input  enable, ch_mask, err_clear, cmd_ready, rsp_valid, rsp_channel, rsp_data,
    output cmd_valid, cmd_channel, cmd_sop, cmd_eop, out_valid, out_channel, out_data,
           scan_done, overrun_err, timeout_err, mismatch_err
  );

  modport slave (
    output enable, ch_mask, err_clear, cmd_ready, rsp_valid, rsp_channel, rsp_data,
    input  cmd_valid, cmd_channel, cmd_sop, cmd_eop, out_valid, out_channel, out_data,
           scan_done, overrun_err, timeout_err, mismatch_err
  );
endinterface
`default_nettype wire

// File: rtl/adc_multich_sampler.sv
`default_nettype none
// ============================================================================
// Module      : adc_multich_sampler
// Description : Multi-channel scan sequencer for the MAX10 modular ADC core.
//               Issues one conversion at a time over the enabled channels on
//               each scan tick, box-car averages 2^AVG_LOG2 scans per channel
//               and emits tagged averaged samples. Flags overrun, response
//               timeout and response channel mismatch.
//   sys_clk_i : system clock
//   reset_i   : asynchronous active-high reset
//   adc_io    : control / command / response / output bundle (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_multich_sampler #(
  parameter int NUM_CH      = 4,
  parameter int CH_BASE     = 1,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int SCAN_DIV    = 1000,
  parameter int RSP_TIMEOUT = 255
) (
  input  wire logic             sys_clk_i,
  input  wire logic             reset_i,
  adc_multich_sampler_if.master adc_io
);
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TMO_W  = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int SCN_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_NEXT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [SCN_W-1:0]   scan_q, scan_d;
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];
  logic               out_valid_q, out_valid_d;
  logic [2:0]         out_channel_q, out_channel_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               scan_done_q, scan_done_d;
  logic               overrun_q, timeout_q, mismatch_q;

  logic               tick;
  logic               last_scan;
  logic               set_ovr, set_tmo, set_mis, clr_avg;
  logic [IDX_W:0]     sel;
  logic [ACC_W-1:0]   sum;
  logic [4:0]         exp_ch;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [IDX_W:0] first_set(input logic [NUM_CH-1:0] m, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  assign exp_ch    = 5'(CH_BASE) + 5'(idx_q);
  assign last_scan = (AVG_LOG2 == 0) || (scan_q == '1);

  // Scan tick generator
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    if (SCAN_DIV == 0) begin
      tick = adc_io.enable;
    end else if (!adc_io.enable) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == TICK_W'(SCAN_DIV - 1)) begin
      tick_cnt_d = '0;
      tick       = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // Sequencer next-state and datapath
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    scan_d        = scan_q;
    acc_d         = acc_q;
    out_valid_d   = 1'b0;
    out_channel_d = out_channel_q;
    out_data_d    = out_data_q;
    scan_done_d   = 1'b0;
    set_tmo       = 1'b0;
    set_mis       = 1'b0;
    clr_avg       = 1'b0;
    sel           = '0;
    sum           = acc_q[idx_q] + ACC_W'(adc_io.rsp_data);

    case (state_q)
      S_IDLE: begin
        if (tick && adc_io.enable && |adc_io.ch_mask) begin
          sel     = first_set(adc_io.ch_mask, 0);
          mask_d  = adc_io.ch_mask;
          idx_d   = sel[IDX_W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (adc_io.cmd_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (adc_io.rsp_valid) begin
          if (adc_io.rsp_channel == exp_ch) begin
            if (last_scan) begin
              out_valid_d   = 1'b1;
              out_channel_d = 3'(idx_q);
              out_data_d    = DATA_W'(sum >> AVG_LOG2);
              acc_d[idx_q]  = '0;
            end else begin
              acc_d[idx_q]  = sum;
            end
            state_d = S_NEXT;
          end else begin
            set_mis = 1'b1;
            clr_avg = 1'b1;
            state_d = S_IDLE;
          end
        end else if (({1'b0, tmo_q} + (TMO_W+1)'(1)) == (TMO_W+1)'(RSP_TIMEOUT)) begin
          set_tmo = 1'b1;
          clr_avg = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_NEXT: begin
        sel = first_set(mask_q, int'(idx_q) + 1);
        if (!adc_io.enable) begin
          // Scan abandoned: a partial average would be meaningless.
          clr_avg = 1'b1;
          state_d = S_IDLE;
        end else if (sel[IDX_W]) begin
          idx_d   = sel[IDX_W-1:0];
          state_d = S_ISSUE;
        end else begin
          scan_done_d = 1'b1;
          scan_d      = last_scan ? '0 : scan_q + SCN_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_avg) begin
      for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
      scan_d = '0;
    end
  end

  // With SCAN_DIV=0 the tick is permanently high, so a busy FSM is the normal
  // back-to-back case and not an overrun.
  assign set_ovr = tick && (state_q != S_IDLE) && (SCAN_DIV != 0);

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      mask_q        <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      scan_q        <= '0;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_data_q    <= '0;
      scan_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      scan_q        <= scan_d;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_data_q    <= out_data_d;
      scan_done_q   <= scan_done_d;
      // A new error in the same cycle as err_clear wins.
      overrun_q     <= set_ovr | (overrun_q  & ~adc_io.err_clear);
      timeout_q     <= set_tmo | (timeout_q  & ~adc_io.err_clear);
      mismatch_q    <= set_mis | (mismatch_q & ~adc_io.err_clear);
    end
  end

  // cmd_valid decodes straight from the async-reset state so it drops at once.
  assign adc_io.cmd_valid    = (state_q == S_ISSUE);
  assign adc_io.cmd_channel  = (state_q == S_ISSUE) ? exp_ch : 5'd0;
  assign adc_io.cmd_sop      = 1'b1;
  assign adc_io.cmd_eop      = 1'b1;
  assign adc_io.out_valid    = out_valid_q;
  assign adc_io.out_channel  = out_channel_q;
  assign adc_io.out_data     = out_data_q;
  assign adc_io.scan_done    = scan_done_q;
  assign adc_io.overrun_err  = overrun_q;
  assign adc_io.timeout_err  = timeout_q;
  assign adc_io.mismatch_err = mismatch_q;

endmodule
`default_nettype wire

// File: doc/adc_multich_sampler.md
Name: adc_multich_sampler

Overview:
- Parametrised multi-channel scan sequencer for the MAX10 modular ADC control core.
- Drives the core's Avalon-ST command port with one outstanding conversion at a time and walks the enabled channels in a scan.
- Scans start on a programmable tick. Each channel's result is box-car averaged over 2^AVG_LOG2 scans and emitted as a tagged sample stream.
- Replaces the fixed single-channel, continuously-valid command scheme and adds overrun, timeout and channel-mismatch detection.

Parameters:
NUM_CH, 4, number of logical channels (1..8); logical channel k maps to ADC channel CH_BASE+k
CH_BASE, 1, ADC channel number of logical channel 0 (1 = Arduino ADC_IN0)
DATA_W, 12, ADC sample width
AVG_LOG2, 2, log2 of scans averaged per output (0..4; 0 = pass-through)
SCAN_DIV, 1000, sys_clk cycles between scan ticks (0 = back-to-back scans)
RSP_TIMEOUT, 255, max cycles from command accept to response before error

Ports:
sys_clk  in  1  system clock (ADC core clock_bridge output)
reset  in  1  asynchronous, active-high reset
enable  in  1  run scans while high
ch_mask  in  NUM_CH  per-channel enable, latched at scan start
err_clear  in  1  one-cycle pulse clears sticky error flags
cmd_valid  out  1  command valid to ADC core
cmd_channel  out  5  ADC channel = CH_BASE + logical index
cmd_sop  out  1  tied 1
cmd_eop  out  1  tied 1
cmd_ready  in  1  command accepted when cmd_valid && cmd_ready
rsp_valid  in  1  response strobe from ADC core
rsp_channel  in  5  channel of response
rsp_data  in  DATA_W  conversion result
out_valid  out  1  one-cycle averaged-sample strobe
out_channel  out  3  logical channel of out_data
out_data  out  DATA_W  averaged sample
scan_done  out  1  one-cycle pulse after last enabled channel of each scan
overrun_err  out  1  sticky: tick arrived while scan busy
timeout_err  out  1  sticky: response not received within RSP_TIMEOUT
mismatch_err  out  1  sticky: rsp_channel differed from issued channel

Behaviour:
- Reset: all outputs 0 except cmd_sop and cmd_eop (constant 1). FSM IDLE, tick counter 0, scan counter 0, all accumulators 0. Takes effect immediately, mid-handshake included: cmd_valid drops asynchronously.
- Tick counter:
  - Runs while enable is high, wraps at SCAN_DIV-1, and asserts tick for one cycle on wrap.
  - SCAN_DIV=0: tick is constantly high.
  - Cleared while enable is low.
- FSM states: IDLE, ISSUE, WAIT_RSP, NEXT.
  - IDLE: on tick && enable && |ch_mask, latch ch_mask, select the lowest set bit, go ISSUE. If ch_mask is all zero, stay IDLE; no command and no scan_done.
  - ISSUE: cmd_valid=1 with cmd_channel held stable until cmd_ready is sampled high, then go WAIT_RSP and load the timeout counter.
  - WAIT_RSP:
    - rsp_valid with matching channel: acc[k] += rsp_data, go NEXT.
    - rsp_valid with non-matching channel: set mismatch_err.
    - Timeout counter reaches RSP_TIMEOUT: set timeout_err.
    - Either error: clear all accumulators and the scan counter, then go IDLE.
  - NEXT: advance to the next set bit of the latched mask and go ISSUE. If none remain, pulse scan_done, increment the scan counter, and go IDLE.
- Averaging and output:
  - Accumulator width is DATA_W+AVG_LOG2.
  - During the scan where scan counter == 2^AVG_LOG2-1, accepting channel k's response makes the following cycle: out_valid=1, out_channel=k, out_data=(acc[k]+rsp_data)>>AVG_LOG2 (truncating).
  - acc[k] clears in the same cycle.
  - The scan counter wraps to 0 after that scan.
- Overrun: tick while FSM is not IDLE sets overrun_err. The tick is dropped; the current scan is unaffected.
- enable falling mid-scan: the outstanding command/response completes (a response is still accumulated), then the FSM goes IDLE and clears the accumulators and scan counter.
- Sticky errors: err_clear clears the flags. If err_clear and a new error set condition occur in the same cycle, set wins.
- Latency: rsp_valid to out_valid is 1 cycle. Minimum command spacing is 3 cycles: ISSUE → WAIT_RSP → NEXT.

Test Plan:
- NUM_CH=4, AVG_LOG2=0, mask=4'b0101, SCAN_DIV=0, responses echo the channel with data 0x123/0x456 → commands on ch 1 and 3 only; out_channel 0 then 2 with out_data 0x123 and 0x456; scan_done once per scan.
- AVG_LOG2=2, ch0 data over four scans 100, 101, 102, 104 → single out_valid with out_data=101 after the 4th scan; acc restarts at 0.
- cmd_ready held low 10 cycles → cmd_valid and cmd_channel stable throughout; exactly one command accepted.
- No response after accept, RSP_TIMEOUT=255 → timeout_err at cycle 255; no out_valid; next scan restarts averaging from zero.
- rsp_channel=5 while channel 2 is outstanding → mismatch_err=1; err_clear pulse → 0; SCAN_DIV=20 with a 30-cycle scan → overrun_err=1.
- Reset asserted during ISSUE → cmd_valid=0 the same cycle; all flags and outputs 0; after release, the first command waits for the next tick.
